// File: rtl/gcd_controller_if.sv
// Handshake and datapath-control bundle between a host/datapath and the GCD controller.
// The master side drives requests and comparison flags; the slave side is the controller.
interface gcd_controller_if;
  logic        start;
  logic        abort;
  logic        a_gt_b;
  logic        b_gt_a;
  logic        a_eq_b;
  logic        ld_a;
  logic        ld_b;
  logic        sub_a;
  logic        sub_b;
  logic        ready;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] iter_count;

  modport master (
    output start, abort, a_gt_b, b_gt_a, a_eq_b,
    input  ld_a, ld_b, sub_a, sub_b, ready, busy, done, error, iter_count
  );

  modport slave (
    input  start, abort, a_gt_b, b_gt_a, a_eq_b,
    output ld_a, ld_b, sub_a, sub_b, ready, busy, done, error, iter_count
  );
endinterface

// File: rtl/gcd_controller.sv
// Subtractive-GCD sequencer: loads operands, steps A-B / B-A until equal, and
// aborts with an error once MAX_ITER subtraction steps have been performed.
module gcd_controller #(
  parameter int unsigned MAX_ITER = 1024
) (
  input logic             clk,
  input logic             rst,
  gcd_controller_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e      state_q;
  logic        ld_q;
  logic        ready_q;
  logic        busy_q;
  logic        done_q;
  logic        error_q;
  logic [31:0] iter_q;

  logic flags_eq;
  logic at_limit;
  logic run_step;

  // All-flags-low is treated as equality so a broken datapath still terminates.
  always_comb begin
    flags_eq = bus.a_eq_b | ~(bus.a_gt_b | bus.b_gt_a);
    at_limit = (iter_q == MAX_ITER);
    run_step = (state_q == StRun) & ~flags_eq & ~at_limit;
  end

  // Subtract strobes depend only on the registered state and datapath flags.
  assign bus.sub_a      = run_step & bus.a_gt_b;
  assign bus.sub_b      = run_step & ~bus.a_gt_b & bus.b_gt_a;
  assign bus.ld_a       = ld_q;
  assign bus.ld_b       = ld_q;
  assign bus.ready      = ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.iter_count = iter_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      ld_q    <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      iter_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q <= StLoad;
            iter_q  <= '0;
            ld_q    <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end

        StLoad: begin
          ld_q <= 1'b0;
          if (bus.abort) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= StRun;
          end
        end

        StRun: begin
          if (bus.abort) begin
            state_q <= StIdle;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end else if (flags_eq) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            error_q <= 1'b0;
          end else if (at_limit) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            error_q <= 1'b1;
          end else if (iter_q != 32'hffff_ffff) begin
            iter_q <= iter_q + 32'd1;
          end
        end

        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          error_q <= 1'b0;
          ready_q <= 1'b1;
        end

        default: begin
          state_q <= StIdle;
          ld_q    <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          error_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_controller.sv
// Bench for gcd_controller: behavioural datapath plus a subtraction-GCD reference model,
// directed corner cases followed by random operand pairs.
module tb_gcd_controller;

  localparam int unsigned MaxIter = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gcd_controller_if bus ();

  gcd_controller #(.MAX_ITER(MaxIter)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural datapath; GCD_OUT is register A.
  logic [15:0] op_a = 16'd0;
  logic [15:0] op_b = 16'd0;
  logic [15:0] reg_a = 16'd0;
  logic [15:0] reg_b = 16'd0;
  logic        flag_mask = 1'b0;

  always @(posedge clk) begin
    if (bus.ld_a) reg_a <= op_a;
    else if (bus.sub_a) reg_a <= reg_a - reg_b;
    if (bus.ld_b) reg_b <= op_b;
    else if (bus.sub_b) reg_b <= reg_b - reg_a;
  end

  assign bus.a_gt_b = !flag_mask && (reg_a > reg_b);
  assign bus.b_gt_a = !flag_mask && (reg_b > reg_a);
  assign bus.a_eq_b = !flag_mask && (reg_a == reg_b);

  int n_ld = 0, n_sa = 0, n_sb = 0, n_done = 0, n_excl = 0;
  always @(negedge clk) begin
    if (bus.ld_a) n_ld++;
    if (bus.sub_a) n_sa++;
    if (bus.sub_b) n_sb++;
    if (bus.done) n_done++;
    if ((bus.sub_a && bus.sub_b) || ((bus.sub_a || bus.sub_b) && (bus.ld_a || bus.ld_b)) ||
        (bus.ld_a != bus.ld_b)) n_excl++;
  end

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: repeated subtraction, equality before step limit, per the controller's rules.
  function automatic void model(input int unsigned a_in, input int unsigned b_in,
                                output int unsigned n, output int unsigned na,
                                output int unsigned nb, output bit err, output int unsigned g);
    int unsigned a;
    int unsigned b;
    a = a_in;
    b = b_in;
    n = 0; na = 0; nb = 0; err = 1'b0;
    while (a != b) begin
      if (n == MaxIter) begin
        err = 1'b1;
        break;
      end
      if (a > b) begin a -= b; na++; end
      else begin b -= a; nb++; end
      n++;
    end
    g = a;
  endfunction

  // Called just after a negedge; returns edges counted since E0 when done is seen.
  task automatic wait_done(input int k0, output int k);
    k = k0;
    while (!bus.done && k < 200) begin
      @(posedge clk);
      k++;
      @(negedge clk);
    end
  endtask

  task automatic do_run(input string tag, input int unsigned a, input int unsigned b);
    int unsigned n, na, nb, g;
    bit err;
    int k, ld0, sa0, sb0, dn0;
    model(a, b, n, na, nb, err, g);
    @(negedge clk);
    check({tag, ":ready"}, {31'd0, bus.ready}, 32'd1);
    #1;
    ld0 = n_ld; sa0 = n_sa; sb0 = n_sb; dn0 = n_done;
    op_a = a[15:0];
    op_b = b[15:0];
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, ":load"}, {30'd0, bus.busy, bus.ld_a}, 32'd3);
    wait_done(0, k);
    check({tag, ":latency"}, k, 2 + n);
    check({tag, ":error"}, {31'd0, bus.error}, {31'd0, err});
    check({tag, ":iter"}, bus.iter_count, n);
    if (!err) check({tag, ":gcd"}, {16'd0, reg_a}, g);
    #1;
    check({tag, ":nsub_a"}, n_sa - sa0, na);
    check({tag, ":nsub_b"}, n_sb - sb0, nb);
    check({tag, ":nld"}, n_ld - ld0, 32'd1);
    check({tag, ":ndone"}, n_done - dn0, 32'd1);
    @(negedge clk);
    check({tag, ":post"}, {30'd0, bus.done, bus.ready}, 32'd1);
    check({tag, ":hold"}, bus.iter_count, n);
  endtask

  initial begin
    int k, ld0, dn0, sa0;
    int unsigned ra, rb;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    rst = 1'b0;
    #12;
    check("rst:flags", {26'd0, bus.ready, bus.busy, bus.done, bus.error, bus.ld_a, bus.sub_a},
          32'h20);
    check("rst:iter", bus.iter_count, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    do_run("r035", 12, 8);
    do_run("r036", 7, 7);
    do_run("r037", 0, 0);
    do_run("r038", 5, 0);

    // Abort in the third RUN cycle.
    @(negedge clk);
    op_a = 16'd1000; op_b = 16'd1;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.abort = 1'b1;
    #1 dn0 = n_done;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort:state", {27'd0, bus.ready, bus.busy, bus.done, bus.sub_a, bus.ld_a}, 32'h10);
    repeat (4) @(negedge clk);
    #1 check("abort:nodone", n_done - dn0, 32'd0);
    do_run("r039", 9, 6);

    // Abort during LOAD.
    @(negedge clk);
    op_a = 16'd12; op_b = 16'd8;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_ld:state", {28'd0, bus.ready, bus.busy, bus.done, bus.ld_a}, 32'h8);

    // Abort is ignored in IDLE.
    @(negedge clk);
    op_a = 16'd7; op_b = 16'd7;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("abort_idle:busy", {31'd0, bus.busy}, 32'd1);
    wait_done(0, k);
    check("abort_idle:latency", k, 32'd2);
    @(negedge clk);

    // All flags low is treated as equality.
    flag_mask = 1'b1;
    #1 sa0 = n_sa + n_sb;
    op_a = 16'd12; op_b = 16'd8;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(0, k);
    check("noflags:latency", k, 32'd2);
    check("noflags:err", {31'd0, bus.error}, 32'd0);
    #1 check("noflags:nsub", n_sa + n_sb - sa0, 32'd0);
    @(negedge clk);
    flag_mask = 1'b0;

    // start held through a whole run is re-accepted only after returning to IDLE.
    @(negedge clk);
    #1 ld0 = n_ld;
    op_a = 16'd7; op_b = 16'd7;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_done(0, k);
    check("held:latency", k, 32'd2);
    #1 check("held:nld1", n_ld - ld0, 32'd1);
    @(negedge clk);
    check("held:idle", {30'd0, bus.ready, bus.busy}, 32'h2);
    @(negedge clk);
    check("held:reload", {30'd0, bus.busy, bus.ld_a}, 32'h3);
    bus.start = 1'b0;
    wait_done(0, k);
    check("held:done2", {31'd0, bus.done}, 32'd1);
    #1 check("held:nld2", n_ld - ld0, 32'd2);
    @(negedge clk);

    // Reset in the middle of RUN, then start on the first edge after release.
    @(negedge clk);
    op_a = 16'd1000; op_b = 16'd1;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst:flags", {26'd0, bus.ready, bus.busy, bus.done, bus.error, bus.ld_a, bus.sub_a},
          32'h20);
    check("midrst:iter", bus.iter_count, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    op_a = 16'd9; op_b = 16'd6;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("midrst:first", {31'd0, bus.busy}, 32'd1);
    wait_done(0, k);
    check("midrst:latency", k, 32'd4);
    check("midrst:gcd", {16'd0, reg_a}, 32'd3);
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom_range(0, 40);
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, 40);
      do_run("rand", ra, rb);
    end

    #1 check("excl", n_excl, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
